// File: rtl/modsq_pkg.sv
// modsq_pkg: shared FSM state, coefficient type and sizing helpers for the modular squaring wrapper
package modsq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  localparam int DEF_MOD_LEN = 1024;
  localparam int DEF_WORD_LEN = 16;
  localparam int DEF_BIT_LEN = 17;
  localparam int DEF_REDUNDANT = 2;
  localparam int CORE_LAT = 3;
  typedef logic [DEF_BIT_LEN-1:0] coef_t;
  function automatic int num_elements(int mod_len, int word_len, int redundant);
    return mod_len / word_len + redundant;
  endfunction
endpackage

// File: rtl/modsq_coef_pipe.sv
// modsq_coef_pipe: coefficient delay line with sideband valid; each stage only loads when its valid arrives, so the output holds the last result
module modsq_coef_pipe #(
  parameter int DEPTH = 1,
  parameter int NUM_ELEMENTS = 66,
  parameter int BIT_LEN = 17
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] in_data,
  output logic                            out_valid,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] out_data
);
  if (DEPTH == 0) begin : g_wire
    assign out_valid = in_valid;
    assign out_data = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] v;
    logic [NUM_ELEMENTS*BIT_LEN-1:0] d [DEPTH];
    always_ff @(posedge clk)
      if (reset) begin
        v <= '0;
        for (int i = 0; i < DEPTH; i++) d[i] <= '0;
      end else begin
        v[0] <= in_valid;
        if (in_valid) d[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
    assign out_valid = v[DEPTH-1];
    assign out_data = d[DEPTH-1];
  end
endmodule

// File: rtl/modsq_core.sv
// modsq_core: free-running squarer mod N = 2^MOD_LEN-59, one squaring and valid pulse every CORE_LAT cycles after start
module modsq_core import modsq_pkg::*; #(
  parameter int MOD_LEN = 1024,
  parameter int WORD_LEN = 16,
  parameter int BIT_LEN = 17,
  parameter int NUM_ELEMENTS = 66
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] sq_in,
  output logic                            valid,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] sq_out
);
  localparam int XW = NUM_ELEMENTS*WORD_LEN + BIT_LEN;
  localparam int NW = MOD_LEN / WORD_LEN;
  localparam logic [MOD_LEN-1:0] MODULUS = {MOD_LEN{1'b1}} - MOD_LEN'(58);
  logic [MOD_LEN-1:0] acc, acc_in, acc_sq;
  logic [XW-1:0] x;
  logic [2*MOD_LEN-1:0] sq;
  logic run, last;
  logic [1:0] cnt;
  always_comb begin
    x = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) x = x + (XW'(sq_in[i*BIT_LEN +: BIT_LEN]) << (i*WORD_LEN));
    acc_in = MOD_LEN'(x % XW'(MODULUS));
    sq = (2*MOD_LEN)'(acc) * (2*MOD_LEN)'(acc);
    acc_sq = MOD_LEN'(sq % (2*MOD_LEN)'(MODULUS));
    sq_out = '0;
    for (int i = 0; i < NW; i++) sq_out[i*BIT_LEN +: BIT_LEN] = BIT_LEN'(acc[i*WORD_LEN +: WORD_LEN]);
  end
  assign last = run && cnt == 2'(CORE_LAT-1);
  always_ff @(posedge clk)
    if (reset) begin
      acc <= '0;
      run <= 1'b0;
      cnt <= '0;
      valid <= 1'b0;
    end else if (start) begin
      acc <= acc_in;
      run <= 1'b1;
      cnt <= '0;
      valid <= 1'b0;
    end else begin
      valid <= last;
      cnt <= last ? 2'd0 : run ? cnt + 2'd1 : cnt;
      if (last) acc <= acc_sq;
    end
endmodule

// File: rtl/modular_square_iter_wrapper.sv
// modular_square_iter_wrapper: runs T squarings on the core with IO_STAGES-deep coefficient pipes; MODSQ_ABORT_EN adds an abort input
module modular_square_iter_wrapper import modsq_pkg::*; #(
  parameter int MOD_LEN = DEF_MOD_LEN,
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int BIT_LEN = DEF_BIT_LEN,
  parameter int REDUNDANT_ELEMENTS = DEF_REDUNDANT,
  parameter int IO_STAGES = 3,
  parameter int ITER_W = 32,
  localparam int NUM_ELEMENTS = num_elements(MOD_LEN, WORD_LEN, REDUNDANT_ELEMENTS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [MOD_LEN-1:0]                 sq_in,
  input  logic [ITER_W-1:0]                  iterations,
`ifdef MODSQ_ABORT_EN
  input  logic                               abort,
`endif
  output logic [NUM_ELEMENTS*2*WORD_LEN-1:0] sq_out,
  output logic                               valid,
  output logic                               busy,
  output logic [ITER_W-1:0]                  iter_done
);
  localparam int CW = NUM_ELEMENTS*BIT_LEN;
  localparam int OW = NUM_ELEMENTS*2*WORD_LEN;
  state_t state, state_n;
  logic [CW-1:0] in_coefs, core_in, core_out, res_data;
  logic [OW-1:0] res_ext, res_q;
  logic [ITER_W-1:0] t_q;
  logic accept, core_start, core_valid, core_reset, in_pv, t_hit, res_valid, kill;
  assign busy = state != IDLE;
  assign accept = start && state == IDLE;
  assign core_start = in_pv && state == LOAD;
  assign t_hit = core_valid && state == RUN && iter_done + ITER_W'(1) == t_q;
`ifdef MODSQ_ABORT_EN
  logic abort_q;
  assign kill = abort && busy;
  always_ff @(posedge clk) abort_q <= reset ? 1'b0 : kill;
  assign core_reset = reset || kill || abort_q;
`else
  assign kill = 1'b0;
  assign core_reset = reset;
`endif
  always_comb begin
    in_coefs = '0;
    for (int i = 0; i < MOD_LEN/WORD_LEN; i++) in_coefs[i*BIT_LEN +: BIT_LEN] = BIT_LEN'(sq_in[i*WORD_LEN +: WORD_LEN]);
    res_ext = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) res_ext[i*2*WORD_LEN +: 2*WORD_LEN] = (2*WORD_LEN)'(res_data[i*BIT_LEN +: BIT_LEN]);
  end
  modsq_coef_pipe #(.DEPTH(IO_STAGES), .NUM_ELEMENTS(NUM_ELEMENTS), .BIT_LEN(BIT_LEN)) u_in_pipe (
    .clk(clk), .reset(reset || kill), .in_valid(accept), .in_data(in_coefs),
    .out_valid(in_pv), .out_data(core_in)
  );
  modsq_core #(.MOD_LEN(MOD_LEN), .WORD_LEN(WORD_LEN), .BIT_LEN(BIT_LEN), .NUM_ELEMENTS(NUM_ELEMENTS)) u_core (
    .clk(clk), .reset(core_reset), .start(core_start), .sq_in(core_in),
    .valid(core_valid), .sq_out(core_out)
  );
  modsq_coef_pipe #(.DEPTH(IO_STAGES-1), .NUM_ELEMENTS(NUM_ELEMENTS), .BIT_LEN(BIT_LEN)) u_out_pipe (
    .clk(clk), .reset(reset || kill), .in_valid(t_hit), .in_data(core_out),
    .out_valid(res_valid), .out_data(res_data)
  );
  assign valid = res_valid;
  assign sq_out = res_valid ? res_ext : res_q;
  always_comb begin
    state_n = state;
    if (kill) state_n = IDLE;
    else if (state == IDLE && start) state_n = LOAD;
    else if (state == LOAD && core_start) state_n = RUN;
    else if (state == RUN && t_hit) state_n = IO_STAGES == 1 ? IDLE : DRAIN;
    else if (state == DRAIN && res_valid) state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      iter_done <= '0;
      t_q <= '0;
      res_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        iter_done <= '0;
        t_q <= iterations == '0 ? ITER_W'(1) : iterations;
      end else if (core_valid && state == RUN) iter_done <= iter_done + ITER_W'(1);
      if (res_valid) res_q <= res_ext;
    end
endmodule

// File: tb/tb_modular_square_iter_wrapper.sv
// tb_modular_square_iter_wrapper: vector table plus random runs against a modular-exponent model, on IO_STAGES=1 and IO_STAGES=8 instances
module tb_modular_square_iter_wrapper;
  localparam int ML = 64;
  localparam int NE = 6;
  localparam int SOW = NE*32;
  localparam int IW = 32;
  localparam logic [127:0] N = 128'hFFFF_FFFF_FFFF_FFC5;

  typedef struct {
    logic [63:0]  x;
    logic [31:0]  t;
    logic [127:0] exp;
    int           mid;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [ML-1:0] sq_in = '0;
  logic [IW-1:0] iterations = '0;
`ifdef MODSQ_ABORT_EN
  logic abort = 1'b0;
`endif
  logic [SOW-1:0] so1, so8;
  logic v1, v8, b1, b8, cv1, cv8;
  logic [IW-1:0] it1, it8;
  int checks = 0, errors = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  modular_square_iter_wrapper #(.MOD_LEN(ML), .WORD_LEN(16), .BIT_LEN(17), .REDUNDANT_ELEMENTS(2), .IO_STAGES(1), .ITER_W(IW)) dut1 (
    .clk(clk), .reset(reset), .start(start), .sq_in(sq_in), .iterations(iterations),
`ifdef MODSQ_ABORT_EN
    .abort(abort),
`endif
    .sq_out(so1), .valid(v1), .busy(b1), .iter_done(it1)
  );
  modular_square_iter_wrapper #(.MOD_LEN(ML), .WORD_LEN(16), .BIT_LEN(17), .REDUNDANT_ELEMENTS(2), .IO_STAGES(8), .ITER_W(IW)) dut8 (
    .clk(clk), .reset(reset), .start(start), .sq_in(sq_in), .iterations(iterations),
`ifdef MODSQ_ABORT_EN
    .abort(abort),
`endif
    .sq_out(so8), .valid(v8), .busy(b8), .iter_done(it8)
  );
  assign cv1 = dut1.core_valid;
  assign cv8 = dut8.core_valid;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model(logic [63:0] x, logic [31:0] t);
    logic [127:0] r;
    r = 128'(x) % N;
    for (int i = 0; i < (t == 0 ? 1 : int'(t)); i++) r = (r * r) % N;
    return r;
  endfunction

  function automatic logic [127:0] reduce(logic [SOW-1:0] s);
    logic [255:0] acc;
    acc = '0;
    for (int i = 0; i < NE; i++) acc = acc + (256'(s[i*32 +: 32]) << (16*i));
    return 128'(acc % 256'(N));
  endfunction

  task automatic run_op(logic [63:0] x, logic [31:0] t, logic [127:0] exp, int mid, string tag);
    int io[2], ncv[2], tc[2], tv[2], nv[2], te;
    bit busy_bad[2];
    logic [127:0] res[2];
    logic vd, bd, cvd;
    io[0] = 1; io[1] = 8;
    te = t == 0 ? 1 : int'(t);
    for (int d = 0; d < 2; d++) begin
      ncv[d] = 0; tc[d] = -100; tv[d] = 0; nv[d] = 0; busy_bad[d] = 0; res[d] = '0;
    end
    @(posedge clk); #1;
    start = 1'b1; sq_in = x; iterations = t;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (n == mid) begin start = 1'b1; sq_in = 64'd7; iterations = 32'd1; end
      if (n == mid + 1) start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        vd = d == 1 ? v8 : v1;
        bd = d == 1 ? b8 : b1;
        cvd = d == 1 ? cv8 : cv1;
        if (n > io[d] && cvd) begin
          ncv[d]++;
          if (ncv[d] == te) tc[d] = n;
        end
        if (vd) begin
          nv[d]++;
          if (nv[d] == 1) begin tv[d] = n; res[d] = reduce(d == 1 ? so8 : so1); end
        end
        if (bd !== (nv[d] == 0 || vd)) busy_bad[d] = 1;
      end
      if (nv[0] > 0 && nv[1] > 0 && n >= tv[0] + 4 && n >= tv[1] + 4) break;
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_io%0d_result", tag, io[d]), res[d], exp);
      check($sformatf("%s_io%0d_iter_done", tag, io[d]), d == 1 ? it8 : it1, te);
      check($sformatf("%s_io%0d_valid_count", tag, io[d]), nv[d], 1);
      check($sformatf("%s_io%0d_latency", tag, io[d]), tv[d] - tc[d], io[d] - 1);
      check($sformatf("%s_io%0d_busy", tag, io[d]), busy_bad[d], 0);
    end
  endtask

  task automatic idle_checks(string tag);
    check({tag, "_sq_out1"}, so1, 0);
    check({tag, "_sq_out8"}, so8, 0);
    check({tag, "_busy1"}, b1, 0);
    check({tag, "_busy8"}, b8, 0);
    check({tag, "_iter1"}, it1, 0);
    check({tag, "_iter8"}, it8, 0);
  endtask

  initial begin
    int bad;
    vecs[0] = '{x: 64'd3, t: 32'd1, exp: 128'd9, mid: -1};
    vecs[1] = '{x: 64'd2, t: 32'd5, exp: 128'h1_0000_0000, mid: -1};
    vecs[2] = '{x: 64'd5, t: 32'd4, exp: 128'd152587890625, mid: 6};
    vecs[3] = '{x: 64'd9, t: 32'd0, exp: 128'd81, mid: -1};
    vecs[4] = '{x: 64'hFFFF_FFFF_FFFF_FFFF, t: 32'd1, exp: 128'd3364, mid: -1};
    for (int i = 5; i < 8; i++) begin
      vecs[i].x = {$urandom, $urandom};
      vecs[i].t = 32'($urandom_range(1, 6));
      vecs[i].exp = model(vecs[i].x, vecs[i].t);
      vecs[i].mid = -1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_valid1", v1, 0);
    check("reset_valid8", v8, 0);
    idle_checks("reset");
    for (int i = 0; i < 8; i++) run_op(vecs[i].x, vecs[i].t, vecs[i].exp, vecs[i].mid, $sformatf("vec%0d", i));

    @(posedge clk); #1;
    start = 1'b1; sq_in = 64'd3; iterations = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      if (v1 || v8) bad++;
      @(posedge clk); #1;
    end
    check("midrst_no_valid", bad, 0);
    idle_checks("midrst");
    run_op(64'd3, 32'd1, 128'd9, -1, "after_rst");

`ifdef MODSQ_ABORT_EN
    @(posedge clk); #1;
    start = 1'b1; sq_in = 64'd3; iterations = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy1", b1, 0);
    check("abort_busy8", b8, 0);
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      if (v1 || v8) bad++;
      @(posedge clk); #1;
    end
    check("abort_no_valid", bad, 0);
    run_op(64'd5, 32'd2, 128'd625, -1, "after_abort");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/modular_square_iter_wrapper.md
MODULAR_SQUARE_ITER_WRAPPER -- requirements
Module: modular_square_iter_wrapper

Interface
REQ-001 Parameter MOD_LEN, default 1024: modulus width in bits; SHALL be a multiple of WORD_LEN.
REQ-002 Parameter WORD_LEN, default 16: non-redundant coefficient width.
REQ-003 Parameter BIT_LEN, default 17: core coefficient width; SHALL be greater than WORD_LEN and at most 2*WORD_LEN.
REQ-004 Parameter REDUNDANT_ELEMENTS, default 2: extra zero-initialised coefficients; NUM_ELEMENTS = MOD_LEN/WORD_LEN + REDUNDANT_ELEMENTS.
REQ-005 Parameter IO_STAGES, default 3, range 1..8: register stages on each of the coefficient input path and coefficient output path.
REQ-006 Parameter ITER_W, default 32: width of the iteration count.
REQ-007 clk  in  1  single clock for the wrapper and the squaring core.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle request; accepted only while busy=0.
REQ-010 sq_in  in  MOD_LEN  base value, captured on the accepted start.
REQ-011 iterations  in  ITER_W  number of squarings T, captured on the accepted start.
REQ-012 sq_out  out  NUM_ELEMENTS*2*WORD_LEN  result coefficients; each BIT_LEN coefficient is zero-extended to 2*WORD_LEN.
REQ-013 valid  out  1  one-cycle pulse; sq_out is correct in this cycle.
REQ-014 busy  out  1  high from the accepted start until the valid pulse, inclusive.
REQ-015 iter_done  out  ITER_W  count of core valid pulses seen in the current run.

Function
REQ-016 FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE -> LOAD on start.
- LOAD -> RUN after IO_STAGES cycles.
- RUN -> DRAIN on the T-th core valid.
- DRAIN -> IDLE on valid.
REQ-017 Start handling: on the accepted start, sq_in is split into WORD_LEN coefficients, each zero-extended to BIT_LEN, and redundant coefficients are set to 0; this data enters the input pipe.
REQ-018 Core start: core start SHALL pulse for exactly one cycle on LOAD exit, aligned with the data reaching input stage IO_STAGES-1.
REQ-019 Counting: iter_done SHALL increment on each core valid during RUN; it is cleared on the accepted start.
REQ-020 Capture: core sq_out SHALL be captured in the cycle of the T-th core valid and then pass through IO_STAGES-1 further output stages.
REQ-021 Output timing: valid SHALL be pipelined in step with the data, so valid asserts exactly IO_STAGES-1 cycles after the T-th core valid.
REQ-022 Output hold: sq_out SHALL hold the last result until the next valid; valid SHALL never be asserted for two consecutive cycles.
REQ-023 iterations=0 SHALL be treated as T=1.
REQ-024 start while busy=1 SHALL be ignored, with no effect on the captured operands or the FSM.
REQ-025 Core valid pulses outside RUN SHALL be ignored.
REQ-026 Simultaneous valid and start in the same cycle: the start is ignored, because busy is still 1 in that cycle.

Reset
REQ-027 On reset the FSM SHALL go to IDLE, and valid=0, busy=0, iter_done=0, sq_out=0, all pipe stages=0.
REQ-028 Core reset SHALL be asserted whenever reset is high; reset mid-run SHALL abort the run with no valid pulse.

Configuration
REQ-029 When MODSQ_ABORT_EN is defined:
- An input port abort (1 bit) exists.
- abort while busy=1 SHALL return the FSM to IDLE next cycle with busy=0 and no valid pulse.
- abort SHALL hold the core in reset for 2 cycles.
- abort while idle SHALL be ignored.
REQ-030 When MODSQ_ABORT_EN is undefined, the abort port and its logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-031 The shared package modsq_pkg SHALL hold:
- the FSM state enum;
- localparam helpers for NUM_ELEMENTS and the coefficient typedef (logic [BIT_LEN-1:0]).
REQ-032 Sub-module modsq_coef_pipe: a parametrised (DEPTH, NUM_ELEMENTS, BIT_LEN) coefficient delay line with a sideband valid bit, instantiated once for the input path and once for the output path.
REQ-033 The squaring core SHALL be instantiated unchanged, on clk and the wrapper-derived core reset.

Verification
REQ-034 Single squaring: reset, then start with sq_in=3 and iterations=1 -> exactly one valid pulse, the reduced sq_out value equals 9, and iter_done=1.
REQ-035 Multiple squarings: sq_in=2, iterations=5 -> reduced sq_out = 2^32 mod N, iter_done=5, busy high from start through valid.
REQ-036 Pipe-depth latency: IO_STAGES=1 and IO_STAGES=8 -> valid follows the T-th core valid by 0 and 7 cycles respectively.
REQ-037 Ignored start: a second start with sq_in=7 in the middle of a run -> ignored; the result still corresponds to the first sq_in.
REQ-038 Reset mid-run: reset asserted during RUN -> no valid pulse, all outputs 0; a fresh start with sq_in=3, T=1 then gives 9.
REQ-039 Abort (MODSQ_ABORT_EN defined): abort during RUN -> busy=0 next cycle and no valid pulse; a following run completes correctly.
